// File: rtl/spi_audio_rx_if.sv
// Bus bundle for spi_audio_rx: the serial Pico side plus the buffered audio-word side.
// The receiver uses the slave modport; the driver/consumer uses master.
interface spi_audio_rx_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 8
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic                  sclk_in;
    logic                  mosi_in;
    logic                  active;
    logic [DATA_WIDTH-1:0] audio_out;
    logic [CH_W-1:0]       channel_out;
    logic                  data_ready;
    logic                  data_ack;
    logic [LVL_W-1:0]      fifo_level;
    logic                  overrun;
    logic                  frame_error;
    logic                  clear_flags;

    modport slave (
        input  sclk_in, mosi_in, active, data_ack, clear_flags,
        output audio_out, channel_out, data_ready, fifo_level, overrun, frame_error
    );

    modport master (
        output sclk_in, mosi_in, active, data_ack, clear_flags,
        input  audio_out, channel_out, data_ready, fifo_level, overrun, frame_error
    );
endinterface

// File: rtl/spi_audio_rx.sv
// Deserialises an active-framed sclk/mosi stream into multi-channel audio words,
// buffered in a first-word-fall-through FIFO with sticky overrun/frame error flags.
module spi_audio_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CH      = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter bit MSB_FIRST   = 1'b1,
    parameter bit SAMPLE_EDGE = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input logic          clock_max,
    input logic          reset,
    spi_audio_rx_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = DATA_WIDTH + CH_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync_r, mosi_sync_r, active_sync_r;
    logic                   sclk_dly_r;
    logic                   sclk_s, mosi_s, active_s, strobe_s;

    logic [0:0]            state_r;
    logic [DATA_WIDTH-1:0] shift_r, shift_next_s;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [CH_W-1:0]       ch_cnt_r, ch_next_s;
    logic                  last_bit_s, frame_err_set_s;
    logic                  push_r;
    logic [DATA_WIDTH-1:0] push_data_r;
    logic [CH_W-1:0]       push_ch_r;

    logic [ENT_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, rd_next_s;
    logic [LVL_W-1:0] count_r, count_next_s;
    logic             full_s, pop_s, push_ok_s, overrun_set_s;
    logic [ENT_W-1:0] push_ent_s, head_next_s, head_r;
    logic             data_ready_r, overrun_r, frame_error_r;

    // Synchronisers; the extra sclk flop gives the edge detector its previous value.
    always_ff @(posedge clock_max or negedge reset) begin
        if (!reset) begin
            sclk_sync_r   <= {SYNC_STAGES{1'b0}};
            mosi_sync_r   <= {SYNC_STAGES{1'b0}};
            active_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_dly_r    <= 1'b0;
        end else begin
            sclk_sync_r   <= {sclk_sync_r[SYNC_STAGES-2:0], bus.sclk_in};
            mosi_sync_r   <= {mosi_sync_r[SYNC_STAGES-2:0], bus.mosi_in};
            active_sync_r <= {active_sync_r[SYNC_STAGES-2:0], bus.active};
            sclk_dly_r    <= sclk_sync_r[SYNC_STAGES-1];
        end
    end

    // Sample strobe, next shift value and counter decode.
    always_comb begin
        sclk_s   = sclk_sync_r[SYNC_STAGES-1];
        mosi_s   = mosi_sync_r[SYNC_STAGES-1];
        active_s = active_sync_r[SYNC_STAGES-1];
        if (SAMPLE_EDGE == 1'b0) begin
            strobe_s = sclk_s & ~sclk_dly_r;
        end else begin
            strobe_s = ~sclk_s & sclk_dly_r;
        end
        if (MSB_FIRST == 1'b1) begin
            shift_next_s = {shift_r[DATA_WIDTH-2:0], mosi_s};
        end else begin
            shift_next_s = {mosi_s, shift_r[DATA_WIDTH-1:1]};
        end
        last_bit_s      = (bit_cnt_r == BIT_W'(DATA_WIDTH - 1));
        ch_next_s       = (ch_cnt_r == CH_W'(NUM_CH - 1)) ? CH_W'(0) : ch_cnt_r + CH_W'(1);
        frame_err_set_s = (state_r == ST_RECV) && !active_s && (bit_cnt_r != BIT_W'(0));
    end

    // Receive FSM; a falling active wins over a same-cycle strobe.
    always_ff @(posedge clock_max or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            shift_r     <= DATA_WIDTH'(0);
            bit_cnt_r   <= BIT_W'(0);
            ch_cnt_r    <= CH_W'(0);
            push_r      <= 1'b0;
            push_data_r <= DATA_WIDTH'(0);
            push_ch_r   <= CH_W'(0);
        end else begin
            push_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (active_s) begin
                        state_r   <= ST_RECV;
                        shift_r   <= DATA_WIDTH'(0);
                        bit_cnt_r <= BIT_W'(0);
                        ch_cnt_r  <= CH_W'(0);
                    end
                end
                ST_RECV: begin
                    if (!active_s) begin
                        state_r <= ST_IDLE;
                    end else if (strobe_s) begin
                        shift_r <= shift_next_s;
                        if (last_bit_s) begin
                            push_r      <= 1'b1;
                            push_data_r <= shift_next_s;
                            push_ch_r   <= ch_cnt_r;
                            bit_cnt_r   <= BIT_W'(0);
                            ch_cnt_r    <= ch_next_s;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // FIFO control; the registered head is the new word when it lands in an otherwise empty queue.
    always_comb begin
        full_s        = (count_r == LVL_W'(FIFO_DEPTH));
        pop_s         = (count_r != LVL_W'(0)) && bus.data_ack;
        push_ok_s     = push_r && (!full_s || pop_s);
        overrun_set_s = push_r && full_s && !pop_s;
        rd_next_s     = pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
        push_ent_s    = {push_ch_r, push_data_r};
        case ({push_ok_s, pop_s})
            2'b10:   count_next_s = count_r + LVL_W'(1);
            2'b01:   count_next_s = count_r - LVL_W'(1);
            default: count_next_s = count_r;
        endcase
        if (push_ok_s && (count_next_s == LVL_W'(1))) begin
            head_next_s = push_ent_s;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // FIFO storage array.
    always_ff @(posedge clock_max) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_ent_s;
        end
    end

    // FIFO pointers, level and registered head outputs.
    always_ff @(posedge clock_max or negedge reset) begin
        if (!reset) begin
            wr_ptr_r     <= PTR_W'(0);
            rd_ptr_r     <= PTR_W'(0);
            count_r      <= LVL_W'(0);
            head_r       <= ENT_W'(0);
            data_ready_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r     <= rd_next_s;
            count_r      <= count_next_s;
            data_ready_r <= (count_next_s != LVL_W'(0));
            if (count_next_s != LVL_W'(0)) begin
                head_r <= head_next_s;
            end
        end
    end

    // Sticky flags; a set event beats a simultaneous clear.
    always_ff @(posedge clock_max or negedge reset) begin
        if (!reset) begin
            overrun_r     <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (bus.clear_flags) begin
                overrun_r <= 1'b0;
            end
            if (frame_err_set_s) begin
                frame_error_r <= 1'b1;
            end else if (bus.clear_flags) begin
                frame_error_r <= 1'b0;
            end
        end
    end

    assign bus.audio_out   = head_r[DATA_WIDTH-1:0];
    assign bus.channel_out = head_r[ENT_W-1:DATA_WIDTH];
    assign bus.data_ready  = data_ready_r;
    assign bus.fifo_level  = count_r;
    assign bus.overrun     = overrun_r;
    assign bus.frame_error = frame_error_r;
endmodule

// File: doc/spi_audio_rx.md
# spi_audio_rx

Parametrised successor to the single-channel 16-bit Pico audio receiver. It deserialises an SPI-style stream (sclk/mosi framed by `active`) from the Pico into configurable-width, multi-channel audio words. Words are buffered in an internal first-word-fall-through FIFO with a valid/ack handshake, so the downstream audio path can stall without losing samples. Sticky error flags report overrun and truncated words.

## Interface
Parameters:
- `DATA_WIDTH`, 16: bits per audio word, 8..32.
- `NUM_CH`, 2: channels per frame, interleaved ch0, ch1, …; 1..8.
- `FIFO_DEPTH`, 8: output FIFO entries; power of two, ≥2.
- `MSB_FIRST`, 1: 1 = first received bit is the word MSB; 0 = first bit is the LSB.
- `SAMPLE_EDGE`, 0: 0 = sample mosi on the sclk rising edge; 1 = on the falling edge.
- `SYNC_STAGES`, 2: synchroniser depth for sclk/mosi/active, ≥2.

Ports:
- `clock_max` in 1: system clock, 25 MHz nominal; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `sclk_in` in 1: Pico serial clock, asynchronous.
- `mosi_in` in 1: Pico serial data, asynchronous.
- `active` in 1: frame enable from the Pico, active-high, asynchronous.
- `audio_out` out DATA_WIDTH: FIFO head word.
- `channel_out` out max(1,$clog2(NUM_CH)): channel index of the head word.
- `data_ready` out 1: head valid (FIFO not empty).
- `data_ack` in 1: consumer accepts head; pop when `data_ready && data_ack`.
- `fifo_level` out $clog2(FIFO_DEPTH+1): occupied entries.
- `overrun` out 1: sticky; a completed word was dropped because the FIFO was full.
- `frame_error` out 1: sticky; `active` fell mid-word.
- `clear_flags` in 1: synchronous clear of both sticky flags.

## Operation
- sclk, mosi and active each pass through `SYNC_STAGES` flops. The sample strobe is the selected edge of synchronised sclk, detected by comparing the last stage with one extra delayed flop. mosi and active use the same depth, so they stay aligned with the strobe.
- FSM states:
  - IDLE → RECEIVING on synchronised active = 1. On entry: shift register, bit counter and channel counter cleared.
  - RECEIVING, strobe:
    - MSB_FIRST=1: shift left, mosi enters bit 0.
    - MSB_FIRST=0: shift right, mosi enters bit DATA_WIDTH-1.
    - bit counter +1.
  - RECEIVING, strobe with bit counter = DATA_WIDTH-1: push {completed word including this bit, channel counter}. Bit counter → 0. Channel counter → (ch+1) mod NUM_CH. State stays RECEIVING.
  - RECEIVING, synchronised active = 0: → IDLE.
    - If bit counter ≠ 0: partial word discarded and frame_error set.
    - If bit counter = 0: clean end, no flag, even when the channel counter ≠ 0.
  - active = 0 takes priority over a strobe in the same cycle; that strobe is ignored.
- FIFO:
  - Push while full (and no pop that cycle): word dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle while full: both occur, level unchanged, no overrun.
  - Pop while empty is ignored; `data_ack` is don't-care when data_ready = 0.
  - Pointers wrap modulo FIFO_DEPTH. The level counter is one bit wider than the pointers.
- Flags:
  - `clear_flags` clears overrun and frame_error.
  - A set event in the same cycle as `clear_flags` wins; the flag reads 1 next cycle.

## Timing
- Reset values: audio_out = 0, channel_out = 0, data_ready = 0, fifo_level = 0, overrun = 0, frame_error = 0, FSM = IDLE, all counters = 0, synchronisers = 0.
- Reset mid-word or mid-frame: everything is discarded, no flag is set, and the block returns to IDLE.
- Latency:
  - Last-bit sclk edge at the pin to the push clock edge: SYNC_STAGES+1 cycles.
  - data_ready (and updated fifo_level) high on the cycle after the push: SYNC_STAGES+2 cycles total from the pin edge.
- audio_out/channel_out are registered, FWFT: valid in the same cycle data_ready is high.
- After a pop, the next entry appears on the following cycle, or data_ready drops to 0.
- Sustained throughput: one pop per cycle.
- sclk high and low phases must each last ≥ SYNC_STAGES+1 clock_max cycles (≤ 4.1 MHz at 25 MHz, SYNC_STAGES=2).
- active must be asserted ≥ SYNC_STAGES+1 cycles before the first sampling edge.

## Test plan
- Defaults, active high, send 0xA5C3 then 0x1234 MSB-first, data_ack = 1 → audio_out 0xA5C3 with ch 0, then 0x1234 with ch 1, each data_ready for one cycle; first word appears 4 cycles after its last rising sclk edge.
- MSB_FIRST=0, DATA_WIDTH=24, NUM_CH=1, send bit stream of 0x00ABCD LSB-first → audio_out 0x00ABCD, channel_out 0.
- data_ack = 0, send 10 words 1..10 (FIFO_DEPTH=8) → fifo_level 8, overrun 1, then draining yields 1..8 in order; clear_flags → overrun 0.
- Drop active after 5 bits → frame_error 1, no push; reassert active and send 0xBEEF → audio_out 0xBEEF, ch 0.
- FIFO full with data_ack = 1 exactly when the 9th word's push occurs → no overrun, level stays 8; clear_flags coinciding with a new overrun → overrun stays 1.
- Assert reset (low) mid-word with 3 entries queued → all outputs 0 next edge; after release a fresh word 0x0F0F is received correctly on ch 0.
